// File: rtl/bin2bcd_disp_feed_pkg.sv
// Shared constants, state encoding and helpers for the binary-to-BCD display feed.
// Sized for the 8-digit seven-segment scan driver.
package bin2bcd_disp_feed_pkg;

    localparam int DIGITS = 8;
    localparam int BCD_W  = 4;
    localparam int DCNT_W = 4;

    // Compile-time power of ten, used for the overflow threshold.
    function automatic longint pow10(input int n);
        longint r;
        r = 64'sd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'sd10;
        end
        return r;
    endfunction

    localparam longint MAX_DEC = pow10(DIGITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/bin2bcd_disp_feed_add3.sv
// Single-nibble correction step of the shift-add-3 conversion:
// any digit of 5 or more is bumped by 3 so the following left shift carries correctly.
module bcd_add3_nibble (
    input  logic [3:0] Nib_In,
    output logic [3:0] Nib_Out
);

    // Add-3 correction for one BCD digit
    always_comb begin
        Nib_Out = Nib_In;
        if (Nib_In >= 4'd5) begin
            Nib_Out = Nib_In + 4'd3;
        end else begin
            Nib_Out = Nib_In;
        end
    end

endmodule

// File: rtl/bin2bcd_disp_feed.sv
// Sequential double-dabble converter feeding the seven-segment scan driver.
// Result, digit count and overflow flag are updated together on completion and held otherwise.
module bin2bcd_disp_feed #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = bin2bcd_disp_feed_pkg::DIGITS
) (
    input  logic                                     Clk,
    input  logic                                     Reset,
    input  logic                                     Start,
    input  logic [BIN_W-1:0]                         Bin_In,
    output logic                                     Busy,
    output logic                                     Done,
    output logic [4*DIGITS-1:0]                      Disp_Data,
    output logic [bin2bcd_disp_feed_pkg::DCNT_W-1:0] Digit_Cnt,
    output logic                                     Ovf
);

    import bin2bcd_disp_feed_pkg::*;

    localparam int          DIG_W     = BCD_W * DIGITS;
    localparam int          SR_W      = DIG_W + BIN_W;
    localparam int          CNT_W     = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_DEC_L = 64'(pow10(DIGITS));

    state_e              state_r;
    state_e              state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [SR_W-1:0]     sr_r;
    logic [BIN_W-1:0]    bin_r;
    logic [SR_W-1:0]     adj_s;
    logic [SR_W-1:0]     sr_shift_s;
    logic [DIG_W-1:0]    bcd_s;
    logic [DCNT_W-1:0]   dcnt_s;
    logic                ovf_s;
    logic                last_shift_s;

    // One add-3 corrector per BCD digit; the binary tail passes straight through
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .Nib_In  (sr_r[BIN_W + g*BCD_W +: BCD_W]),
            .Nib_Out (adj_s[BIN_W + g*BCD_W +: BCD_W])
        );
    end

    assign adj_s[BIN_W-1:0] = sr_r[BIN_W-1:0];
    // Whole-register shift: the bit leaving the top digit is a ten-millions carry we do not keep
    assign sr_shift_s       = adj_s << 1;
    assign bcd_s            = sr_r[SR_W-1 -: DIG_W];
    assign last_shift_s     = (cnt_r == CNT_W'(BIN_W - 1));
    assign ovf_s            = (64'(bin_r) >= MAX_DEC_L);

    // Significant-digit count: position of the highest nonzero digit, minimum one
    always_comb begin
        dcnt_s = DCNT_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_s[i*BCD_W +: BCD_W] != 4'd0) begin
                dcnt_s = DCNT_W'(i + 1);
            end else begin
                dcnt_s = dcnt_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_shift_s) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_r     <= '0;
            sr_r      <= '0;
            bin_r     <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Disp_Data <= '0;
            Digit_Cnt <= '0;
            Ovf       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        sr_r  <= {{DIG_W{1'b0}}, Bin_In};
                        bin_r <= Bin_In;
                        cnt_r <= '0;
                        Busy  <= 1'b1;
                    end else begin
                        Busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    sr_r  <= sr_shift_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    Busy  <= 1'b1;
                    Done  <= 1'b0;
                end
                FINISH: begin
                    Busy <= 1'b0;
                    Done <= 1'b1;
                    Ovf  <= ovf_s;
                    if (ovf_s) begin
                        Disp_Data <= {DIGITS{4'h9}};
                        Digit_Cnt <= DCNT_W'(DIGITS);
                    end else begin
                        Disp_Data <= bcd_s;
                        Digit_Cnt <= dcnt_s;
                    end
                end
                default: begin
                    Busy <= 1'b0;
                    Done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_disp_feed.sv
// Directed self-checking bench for bin2bcd_disp_feed: latency, saturation,
// Start filtering, abort on reset, and a small model-checked sweep.
module tb_bin2bcd_disp_feed;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [26:0] Bin_In;
    logic        Busy;
    logic        Done;
    logic [31:0] Disp_Data;
    logic [3:0]  Digit_Cnt;
    logic        Ovf;

    int n_pass;
    int n_total;

    bin2bcd_disp_feed #(.BIN_W(27), .DIGITS(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Bin_In    (Bin_In),
        .Busy      (Busy),
        .Done      (Done),
        .Disp_Data (Disp_Data),
        .Digit_Cnt (Digit_Cnt),
        .Ovf       (Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_conv(input logic [26:0] v);
        Bin_In = v;
        Start  = 1'b1;
        tick();
        Start  = 1'b0;
    endtask

    // Waits up to 100 edges for Done; reports edges taken, Busy cycles, output stability, Busy/Done overlap
    task automatic wait_done(output int edges, output int busy_cyc, output bit stable, output bit overlap);
        logic [31:0] d0;
        logic [3:0]  c0;
        logic        o0;
        d0 = Disp_Data;
        c0 = Digit_Cnt;
        o0 = Ovf;
        edges    = 0;
        busy_cyc = (Busy === 1'b1) ? 1 : 0;
        stable   = 1'b1;
        overlap  = 1'b0;
        while (Done !== 1'b1 && edges < 100) begin
            tick();
            edges++;
            if (Busy === 1'b1) busy_cyc++;
            if (Busy === 1'b1 && Done === 1'b1) overlap = 1'b1;
            if (Done !== 1'b1 && (Disp_Data !== d0 || Digit_Cnt !== c0 || Ovf !== o0)) stable = 1'b0;
        end
    endtask

    function automatic void model(input int v, output logic [31:0] bcd, output logic [3:0] cnt, output logic ovf);
        int t;
        if (v >= 100000000) begin
            bcd = 32'h9999_9999;
            cnt = 4'd8;
            ovf = 1'b1;
        end else begin
            t   = v;
            bcd = 32'h0;
            cnt = 4'd1;
            for (int i = 0; i < 8; i++) begin
                bcd[i*4 +: 4] = 4'(t % 10);
                if (t % 10 != 0) cnt = 4'(i + 1);
                t = t / 10;
            end
            ovf = 1'b0;
        end
    endfunction

    task automatic test_reset();
        Reset  = 1'b1;
        Start  = 1'b0;
        Bin_In = 27'd0;
        tick();
        tick();
        Reset = 1'b0;
        n_total++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy); else n_pass++;
        n_total++; if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done); else n_pass++;
        n_total++; if (Disp_Data !== 32'h0) $display("FAIL reset_disp got %h want 00000000", Disp_Data); else n_pass++;
        n_total++; if (Digit_Cnt !== 4'd0) $display("FAIL reset_dcnt got %0d want 0", Digit_Cnt); else n_pass++;
        n_total++; if (Ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", Ovf); else n_pass++;
    endtask

    task automatic test_zero();
        int e, b;
        bit s, o;
        start_conv(27'd0);
        n_total++; if (Busy !== 1'b1) $display("FAIL zero_busy_after_start got %b want 1", Busy); else n_pass++;
        wait_done(e, b, s, o);
        n_total++; if (e !== 28) $display("FAIL zero_latency got %0d edges after start want 28", e); else n_pass++;
        n_total++; if (Disp_Data !== 32'h0000_0000) $display("FAIL zero_disp got %h want 00000000", Disp_Data); else n_pass++;
        n_total++; if (Digit_Cnt !== 4'd1) $display("FAIL zero_dcnt got %0d want 1", Digit_Cnt); else n_pass++;
        n_total++; if (Ovf !== 1'b0) $display("FAIL zero_ovf got %b want 0", Ovf); else n_pass++;
        tick();
        n_total++; if (Done !== 1'b0) $display("FAIL zero_done_width got %b want 0", Done); else n_pass++;
    endtask

    task automatic test_12345();
        int e, b;
        bit s, o;
        start_conv(27'd12345);
        wait_done(e, b, s, o);
        n_total++; if (Disp_Data !== 32'h0001_2345) $display("FAIL d12345_disp got %h want 00012345", Disp_Data); else n_pass++;
        n_total++; if (Digit_Cnt !== 4'd5) $display("FAIL d12345_dcnt got %0d want 5", Digit_Cnt); else n_pass++;
        n_total++; if (Ovf !== 1'b0) $display("FAIL d12345_ovf got %b want 0", Ovf); else n_pass++;
        n_total++; if (b !== 28) $display("FAIL d12345_busy_len got %0d want 28", b); else n_pass++;
        n_total++; if (o !== 1'b0) $display("FAIL d12345_busy_done_overlap got %b want 0", o); else n_pass++;
        n_total++; if (s !== 1'b1) $display("FAIL d12345_hold got %b want 1", s); else n_pass++;
    endtask

    task automatic test_max();
        int e, b;
        bit s, o;
        start_conv(27'd99999999);
        wait_done(e, b, s, o);
        n_total++; if (Disp_Data !== 32'h9999_9999) $display("FAIL max_disp got %h want 99999999", Disp_Data); else n_pass++;
        n_total++; if (Digit_Cnt !== 4'd8) $display("FAIL max_dcnt got %0d want 8", Digit_Cnt); else n_pass++;
        n_total++; if (Ovf !== 1'b0) $display("FAIL max_ovf got %b want 0", Ovf); else n_pass++;
        tick();
        start_conv(27'd100000000);
        wait_done(e, b, s, o);
        n_total++; if (Disp_Data !== 32'h9999_9999) $display("FAIL ovf_disp got %h want 99999999", Disp_Data); else n_pass++;
        n_total++; if (Digit_Cnt !== 4'd8) $display("FAIL ovf_dcnt got %0d want 8", Digit_Cnt); else n_pass++;
        n_total++; if (Ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", Ovf); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e, b;
        bit s, o;
        tick();
        start_conv(27'd7);
        repeat (9) tick();
        Bin_In = 27'd42;
        Start  = 1'b1;
        tick();
        Start  = 1'b0;
        wait_done(e, b, s, o);
        n_total++; if (Disp_Data !== 32'h0000_0007) $display("FAIL ignore_disp got %h want 00000007", Disp_Data); else n_pass++;
        n_total++; if (Digit_Cnt !== 4'd1) $display("FAIL ignore_dcnt got %0d want 1", Digit_Cnt); else n_pass++;
        start_conv(27'd42);
        n_total++; if (Busy !== 1'b1) $display("FAIL b2b_accept got busy %b want 1", Busy); else n_pass++;
        wait_done(e, b, s, o);
        n_total++; if (e !== 28) $display("FAIL b2b_latency got %0d edges want 28", e); else n_pass++;
        n_total++; if (Disp_Data !== 32'h0000_0042) $display("FAIL b2b_disp got %h want 00000042", Disp_Data); else n_pass++;
        n_total++; if (Digit_Cnt !== 4'd2) $display("FAIL b2b_dcnt got %0d want 2", Digit_Cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit saw;
        tick();
        start_conv(27'd555);
        repeat (11) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_total++; if (Busy !== 1'b0) $display("FAIL abort_busy got %b want 0", Busy); else n_pass++;
        n_total++; if (Done !== 1'b0) $display("FAIL abort_done got %b want 0", Done); else n_pass++;
        n_total++; if (Disp_Data !== 32'h0) $display("FAIL abort_disp got %h want 00000000", Disp_Data); else n_pass++;
        n_total++; if (Digit_Cnt !== 4'd0) $display("FAIL abort_dcnt got %0d want 0", Digit_Cnt); else n_pass++;
        n_total++; if (Ovf !== 1'b0) $display("FAIL abort_ovf got %b want 0", Ovf); else n_pass++;
        saw = 1'b0;
        repeat (35) begin
            tick();
            if (Done !== 1'b0 || Busy !== 1'b0) saw = 1'b1;
        end
        n_total++; if (saw !== 1'b0) $display("FAIL abort_quiet got activity %b want 0", saw); else n_pass++;
    endtask

    task automatic test_sweep();
        int e, b, v;
        bit s, o;
        logic [31:0] exp_bcd;
        logic [3:0]  exp_cnt;
        logic        exp_ovf;
        for (int k = 0; k < 150; k++) begin
            if (k % 2 == 0) v = int'($urandom_range(0, 134217727));
            else            v = int'($urandom_range(0, 99999));
            model(v, exp_bcd, exp_cnt, exp_ovf);
            start_conv(27'(v));
            wait_done(e, b, s, o);
            n_total++; if (Disp_Data !== exp_bcd) $display("FAIL sweep_disp v=%0d got %h want %h", v, Disp_Data, exp_bcd); else n_pass++;
            n_total++; if (Digit_Cnt !== exp_cnt) $display("FAIL sweep_dcnt v=%0d got %0d want %0d", v, Digit_Cnt, exp_cnt); else n_pass++;
            n_total++; if (Ovf !== exp_ovf) $display("FAIL sweep_ovf v=%0d got %b want %b", v, Ovf, exp_ovf); else n_pass++;
            n_total++; if (s !== 1'b1 || o !== 1'b0) $display("FAIL sweep_hold v=%0d got stable=%b overlap=%b want 1/0", v, s, o); else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_zero();
        test_12345();
        test_max();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
